// File: rtl/gray_pkg.sv
// +------------------------------------------------------------------+
// | gray_pkg : shared types and constants for the Gray decoder        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package gray_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } gray_dec_state_t;

    localparam int ERR_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// +------------------------------------------------------------------+
// | gray_to_bin : combinational WIDTH-bit Gray to binary converter    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of all Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/gray_decoder.sv
// +------------------------------------------------------------------+
// | gray_decoder : synchronise, decode and step-check a Gray count bus |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_gray,
    input  logic                 i_clr,
    output logic [WIDTH-1:0]     o_bin,
    output logic                 o_valid,
    output logic                 o_dir,
    output logic                 o_step_err,
    output logic                 o_fault,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0]    FILL_DONE = FILL_W'(SYNC_STAGES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  dec;
    logic [WIDTH-1:0]                  bin_up;
    logic [WIDTH-1:0]                  bin_dn;
    logic [FILL_W-1:0]                 fill_cnt;
    gray_dec_state_t                   state;

    // A whole-bus flop chain is safe: only one Gray bit moves per step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_gray};
        end
    end

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (sync_q[SYNC_STAGES-1]),
        .bin  (dec)
    );

    assign bin_up = o_bin + WIDTH'(1);
    assign bin_dn = o_bin - WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_INIT;
            fill_cnt   <= '0;
            o_bin      <= '0;
            o_valid    <= 1'b0;
            o_dir      <= 1'b0;
            o_step_err <= 1'b0;
            o_fault    <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_step_err <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (fill_cnt == FILL_DONE) begin
                        o_bin   <= dec;
                        o_valid <= 1'b1;
                        state   <= ST_TRACK;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    if (dec == bin_up) begin
                        o_bin   <= dec;
                        o_valid <= 1'b1;
                        o_dir   <= 1'b1;
                    end else if (dec == bin_dn) begin
                        o_bin   <= dec;
                        o_valid <= 1'b1;
                        o_dir   <= 1'b0;
                    end else if (dec != o_bin) begin
                        o_bin      <= dec;
                        o_valid    <= 1'b1;
                        o_step_err <= 1'b1;
                        o_fault    <= 1'b1;
                        state      <= ST_FAULT;
                        if (o_err_cnt != ERR_MAX) begin
                            o_err_cnt <= o_err_cnt + 1'b1;
                        end
                    end
                    // Clear wins over a same-cycle illegal step's bookkeeping.
                    if (i_clr) begin
                        o_err_cnt <= '0;
                        o_fault   <= 1'b0;
                        state     <= ST_TRACK;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_decoder.sv
// +------------------------------------------------------------------+
// | tb_gray_decoder : directed scoreboard bench for gray_decoder      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gray_decoder;
    import gray_pkg::*;

    localparam int W   = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [W-1:0]         gray  = '0;
    logic                 clr   = 1'b0;
    logic [W-1:0]         o_bin;
    logic                 o_valid;
    logic                 o_dir;
    logic                 o_step_err;
    logic                 o_fault;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    gray_decoder #(
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_gray     (gray),
        .i_clr      (clr),
        .o_bin      (o_bin),
        .o_valid    (o_valid),
        .o_dir      (o_dir),
        .o_step_err (o_step_err),
        .o_fault    (o_fault),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] bin;
        logic         dir;
        logic         err;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0] m_bin   = '0;
    logic         m_dir   = 1'b0;
    logic         m_fault = 1'b0;
    int           m_cnt   = 0;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every o_valid consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() != 0 && cyc > sb[0].due) begin
                chk("missing_valid", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("bin", o_bin, e_mon.bin);
                    chk("dir", o_dir, e_mon.dir);
                    chk("step_err", o_step_err, e_mon.err);
                    chk("latency", cyc, e_mon.due);
                end
            end else if (o_step_err) begin
                chk("stray_step_err", 32'd1, 32'd0);
            end
        end
    end

    // Drive a code at a falling edge; push what the DUT must report LAT cycles later.
    task automatic drive(input logic [W-1:0] g, input int hold, input logic with_clr = 1'b0);
        logic [W-1:0] d;
        logic [W-1:0] diff;
        exp_t e;
        gray = g;
        d    = g2b(g);
        diff = d - m_bin;
        if (diff != '0) begin
            e.bin = d;
            e.err = 1'b0;
            e.due = cyc + LAT;
            if (diff == W'(1)) m_dir = 1'b1;
            else if (diff == {W{1'b1}}) m_dir = 1'b0;
            else begin
                e.err   = 1'b1;
                m_fault = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            e.dir = m_dir;
            m_bin = d;
            sb.push_back(e);
        end
        if (with_clr) begin
            repeat (LAT - 1) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr     = 1'b0;
            m_cnt   = 0;
            m_fault = 1'b0;
        end else begin
            repeat (hold) @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_fault"}, o_fault, m_fault);
        chk({tag, "_err_cnt"}, o_err_cnt, m_cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"}, o_bin, 32'd0);
        chk({tag, "_valid"}, o_valid, 32'd0);
        chk({tag, "_dir"}, o_dir, 32'd0);
        chk({tag, "_step_err"}, o_step_err, 32'd0);
        chk({tag, "_fault"}, o_fault, 32'd0);
        chk({tag, "_err_cnt"}, o_err_cnt, 32'd0);
    endtask

    task automatic acquire();
        exp_t e;
        m_bin   = g2b(gray);
        m_dir   = 1'b0;
        m_fault = 1'b0;
        m_cnt   = 0;
        e.bin = m_bin;
        e.dir = 1'b0;
        e.err = 1'b0;
        e.due = cyc + LAT;
        rst_n = 1'b1;
        sb.push_back(e);
    endtask

    initial begin
        // Reset and acquire on 0110 (binary 4).
        gray  = 4'b0110;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        acquire();
        drain();
        chk("acq_bin", o_bin, 32'd4);
        check_status("acq");

        // Legal walk down to 0, then up 1..3.
        drive(4'b0010, 3);
        drive(4'b0011, 3);
        drive(4'b0001, 3);
        drive(4'b0000, 3);
        drain();
        chk("down_bin", o_bin, 32'd0);
        chk("down_dir", o_dir, 32'd0);
        drive(4'b0001, 3);
        drive(4'b0011, 3);
        drive(4'b0010, 3);
        drain();
        chk("up_bin", o_bin, 32'd3);
        chk("up_dir", o_dir, 32'd1);
        check_status("up");

        // Wrap in both directions.
        drive(4'b0011, 3);
        drive(4'b0001, 3);
        drive(4'b0000, 3);
        drive(4'b1000, 3);
        drive(4'b0000, 3);
        drain();
        chk("wrap_up_bin", o_bin, 32'd0);
        chk("wrap_up_dir", o_dir, 32'd1);
        drive(4'b1000, 3);
        drain();
        chk("wrap_dn_bin", o_bin, 32'd15);
        chk("wrap_dn_dir", o_dir, 32'd0);
        chk("wrap_fault", o_fault, 32'd0);
        drive(4'b0000, 3);

        // Illegal jump 0 -> 2, then a legal step while faulted.
        drive(4'b0011, 3);
        drain();
        chk("jump_bin", o_bin, 32'd2);
        chk("jump_dir", o_dir, 32'd1);
        chk("jump_fault", o_fault, 32'd1);
        chk("jump_err_cnt", o_err_cnt, 32'd1);
        drive(4'b0010, 3);
        drain();
        chk("after_jump_bin", o_bin, 32'd3);
        chk("after_jump_fault", o_fault, 32'd1);
        check_status("after_jump");

        // Saturate the error counter with single-cycle codes.
        for (int j = 0; j < 300; j++) drive((j % 2) ? 4'b0011 : 4'b0000, 1);
        drain();
        chk("sat_err_cnt", o_err_cnt, 32'd255);
        chk("sat_fault", o_fault, 32'd1);

        // Clear lands in the same cycle as another illegal jump.
        drive(4'b0000, 3, 1'b1);
        drain();
        chk("clr_err_cnt", o_err_cnt, 32'd0);
        chk("clr_fault", o_fault, 32'd0);

        // Up to 5, then an asynchronous mid-run reset.
        drive(4'b0001, 3);
        drive(4'b0011, 3);
        drive(4'b0010, 3);
        drive(4'b0110, 3);
        drive(4'b0111, 3);
        drain();
        chk("pre_rst_bin", o_bin, 32'd5);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        chk("mid_reset_sb_empty", sb.size(), 32'd0);
        @(negedge clk);
        gray = 4'b0101;
        repeat (2) @(negedge clk);
        acquire();
        drain();
        chk("reacq_bin", o_bin, 32'd6);
        check_status("reacq");
        drive(4'b0111, 3);
        drain();
        chk("post_reacq_bin", o_bin, 32'd5);
        chk("post_reacq_dir", o_dir, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
